// File: rtl/memory_bus_ram_slave_if.sv
// rtl/memory_bus_ram_slave_if.sv - memory_bus interface shared by bus masters and RAM slaves
interface memory_bus;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        write_enable;
  logic        enable;
  logic        data_ready;

  modport slave (
    input  address, data_in, write_enable, enable,
    output data_out, data_ready
  );

  modport master (
    output address, data_in, write_enable, enable,
    input  data_out, data_ready
  );
endinterface

// File: rtl/memory_bus_ram_slave.sv
// rtl/memory_bus_ram_slave.sv - word RAM on the memory_bus slave modport with programmable wait states
module memory_bus_ram_slave #(
  parameter int    ADDR_BITS = 10,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic     clk,
  input  logic     rst,
  memory_bus.slave bus,
  output logic     busy,
  output logic     err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] lat_addr, lat_data;
  logic        lat_we;
  logic [15:0] acc_addr, acc_data;
  logic        acc_we;
  logic        accept, go_done, out_of_range;
  logic [ADDR_BITS-1:0] ram_idx;

  logic [15:0] mem [0:(1<<ADDR_BITS)-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    go_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          accept  = 1'b1;
          cnt_nxt = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_nxt = DONE;
            go_done   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // An abort wins over completion in the final wait cycle.
        if (!bus.enable) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd1) begin
          state_nxt = DONE;
          go_done   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access happens on the accepting edge, so use live inputs.
  assign acc_addr     = (state == IDLE) ? bus.address      : lat_addr;
  assign acc_data     = (state == IDLE) ? bus.data_in      : lat_data;
  assign acc_we       = (state == IDLE) ? bus.write_enable : lat_we;
  assign out_of_range = (acc_addr >> ADDR_BITS) != 16'h0000;
  assign ram_idx      = acc_addr[ADDR_BITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lat_addr       <= 16'h0000;
      lat_data       <= 16'h0000;
      lat_we         <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
      bus.data_ready <= 1'b0;
      bus.data_out   <= 16'h0000;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      busy           <= (state_nxt == WAIT);
      err            <= go_done && out_of_range;
      bus.data_ready <= go_done;
      if (accept) begin
        lat_addr <= bus.address;
        lat_data <= bus.data_in;
        lat_we   <= bus.write_enable;
      end
      if (go_done && !acc_we) begin
        bus.data_out <= out_of_range ? 16'h0000 : mem[ram_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (go_done && acc_we && !out_of_range && !rst) begin
      mem[ram_idx] <= acc_data;
    end
  end
endmodule

// File: tb/tb_memory_bus_ram_slave.sv
// tb/tb_memory_bus_ram_slave.sv - directed scoreboard bench for memory_bus_ram_slave
module tb_memory_bus_ram_slave;
  logic clk = 1'b0;
  logic rst2, rst0;
  logic busy2, busy0, err2, err0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last2, last0;

  memory_bus b2 ();
  memory_bus b0 ();

  memory_bus_ram_slave #(.ADDR_BITS(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(b2), .busy(busy2), .err(err2)
  );

  memory_bus_ram_slave #(.ADDR_BITS(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(b0), .busy(busy0), .err(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit f, input bit we, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] rd_exp, input bit e_exp, output int dr_at);
    exp_t x;
    int   n;
    int   bn;
    logic dr;
    x.lat = f ? 1 : 3;
    x.err = e_exp;
    if (we) x.data = f ? last0 : last2;
    else    x.data = e_exp ? 16'h0000 : rd_exp;
    sb.push_back(x);
    @(posedge clk); #1;
    if (f) begin
      b0.address = a; b0.data_in = d; b0.write_enable = we; b0.enable = 1'b1;
    end else begin
      b2.address = a; b2.data_in = d; b2.write_enable = we; b2.enable = 1'b1;
    end
    n  = 0;
    bn = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
      dr = f ? b0.data_ready : b2.data_ready;
      if (f ? busy0 : busy2) bn++;
    end while (!dr && n < 20);
    dr_at = cyc;
    x = sb.pop_front();
    chk(f ? "lat0_latency" : "lat2_latency", n, x.lat);
    chk(f ? "lat0_busy_cycles" : "lat2_busy_cycles", bn, x.lat - 1);
    chk(f ? "lat0_data_out" : "lat2_data_out", f ? b0.data_out : b2.data_out, x.data);
    chk(f ? "lat0_err" : "lat2_err", f ? err0 : err2, x.err);
    if (f) last0 = x.data; else last2 = x.data;
  endtask

  task automatic idle(input bit f);
    @(posedge clk); #1;
    if (f) b0.enable = 1'b0; else b2.enable = 1'b0;
  endtask

  initial begin
    int t1, t2, nrd;
    rst2 = 1'b1; rst0 = 1'b1;
    b2.address = '0; b2.data_in = '0; b2.write_enable = 1'b0; b2.enable = 1'b0;
    b0.address = '0; b0.data_in = '0; b0.write_enable = 1'b0; b0.enable = 1'b0;
    last2 = 16'h0000; last0 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0; rst0 = 1'b0;
    chk("reset_ready2", b2.data_ready, 0);
    chk("reset_busy2", busy2, 0);
    chk("reset_err2", err2, 0);
    chk("reset_dout2", b2.data_out, 0);
    chk("reset_ready0", b0.data_ready, 0);
    chk("reset_dout0", b0.data_out, 0);

    req(0, 1, 16'h0010, 16'hBEEF, 0, 0, t1); idle(0);
    req(0, 0, 16'h0010, 0, 16'hBEEF, 0, t1); idle(0);
    repeat (3) @(negedge clk);
    chk("hold_after_read", b2.data_out, 16'hBEEF);
    req(0, 1, 16'h0011, 16'h1234, 0, 0, t1);
    req(0, 0, 16'h0011, 0, 16'h1234, 0, t2); idle(0);
    chk("lat2_spacing", t2 - t1, 4);

    req(0, 1, 16'h0000, 16'hC0DE, 0, 0, t1); idle(0);
    req(0, 1, 16'h0400, 16'hAAAA, 0, 1, t1); idle(0);
    req(0, 0, 16'h0400, 0, 0, 1, t1); idle(0);
    req(0, 0, 16'h0000, 0, 16'hC0DE, 0, t1); idle(0);

    req(0, 1, 16'h0020, 16'h1111, 0, 0, t1); idle(0);
    @(posedge clk); #1;
    b2.address = 16'h0020; b2.data_in = 16'h5555; b2.write_enable = 1'b1; b2.enable = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy_in_wait", busy2, 1);
    b2.enable = 1'b0;
    nrd = 0;
    repeat (5) begin
      @(negedge clk);
      if (b2.data_ready) nrd++;
    end
    chk("abort_no_ready", nrd, 0);
    chk("abort_busy_low", busy2, 0);
    chk("abort_dout_held", b2.data_out, 16'hC0DE);
    req(0, 0, 16'h0020, 0, 16'h1111, 0, t1); idle(0);

    req(0, 1, 16'h0030, 16'h2222, 0, 0, t1); idle(0);
    req(0, 0, 16'h0030, 0, 16'h2222, 0, t1); idle(0);
    @(posedge clk); #1;
    b2.address = 16'h0030; b2.data_in = 16'h7777; b2.write_enable = 1'b1; b2.enable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    b2.enable = 1'b0;
    chk("rst_done_ready", b2.data_ready, 0);
    chk("rst_done_busy", busy2, 0);
    chk("rst_done_dout", b2.data_out, 0);
    last2 = 16'h0000;
    req(0, 0, 16'h0030, 0, 16'h2222, 0, t1); idle(0);

    req(1, 1, 16'h0005, 16'h5A5A, 0, 0, t1); idle(1);
    req(1, 0, 16'h0005, 0, 16'h5A5A, 0, t1);
    req(1, 1, 16'h0006, 16'hA5A5, 0, 0, t2);
    chk("lat0_spacing_rw", t2 - t1, 2);
    req(1, 0, 16'h0006, 0, 16'hA5A5, 0, t1);
    chk("lat0_spacing_wr", t1 - t2, 2);
    idle(1);
    chk("lat0_pulse_width", b0.data_ready, 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
